// File: rtl/fixed8_pkg.sv
// -----------------------------------------------------------------------------
// fixed8_pkg
// Shared definitions for the fixed8 dot-product MAC slice.
//   - state_e        : controller FSM states (IDLE, RUN, DONE)
//   - COL_WIDTH_DEF  : default column width parameter
//   - ACC_W_DEF      : default accumulator width (4 * COL_WIDTH_DEF)
//   - LEN_W_DEF      : default width of the job length field
// -----------------------------------------------------------------------------
package fixed8_pkg;

  localparam int COL_WIDTH_DEF = 11;
  localparam int ACC_W_DEF     = 4 * COL_WIDTH_DEF;
  localparam int LEN_W_DEF     = 8;

  // Controller states. Two bits leave one spare encoding, which the FSM
  // treats as an illegal state and recovers from by returning to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : fixed8_pkg

// File: rtl/fixed8.sv
// -----------------------------------------------------------------------------
// fixed8
// Combinational multiply-accumulate cell: psum_fwd = psum_in + in * weight,
// evaluated modulo 2^ACC_W.
// Ports:
//   in       [7:0]        activation byte
//   weight   [7:0]        weight byte
//   s_in                  activation is signed
//   s_weight              weight is signed
//   psum_in  [ACC_W-1:0]  incoming partial sum
//   psum_fwd [ACC_W-1:0]  partial sum plus this product (wraps on overflow)
// -----------------------------------------------------------------------------
module fixed8
  import fixed8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [7:0]       in,
  input  logic [7:0]       weight,
  input  logic             s_in,
  input  logic             s_weight,
  input  logic [ACC_W-1:0] psum_in,
  output logic [ACC_W-1:0] psum_fwd
);

  logic             in_sign_s;
  logic             weight_sign_s;
  logic [ACC_W-1:0] in_ext_s;
  logic [ACC_W-1:0] weight_ext_s;
  logic [ACC_W-1:0] product_s;

  // The fill bit is the operand MSB only when that operand is declared signed.
  assign in_sign_s     = s_in & in[7];
  assign weight_sign_s = s_weight & weight[7];

  // Extend both operands to the full accumulator width before multiplying.
  // Keeping only the low ACC_W bits of the product gives the correct
  // two's-complement result modulo 2^ACC_W for every signedness combination.
  always_comb begin
    in_ext_s     = {{(ACC_W-8){in_sign_s}}, in};
    weight_ext_s = {{(ACC_W-8){weight_sign_s}}, weight};
    product_s    = in_ext_s * weight_ext_s;
    psum_fwd     = psum_in + product_s;
  end

endmodule : fixed8

// File: rtl/fixed8_mac_seq.sv
// -----------------------------------------------------------------------------
// fixed8_mac_seq
// Sequential dot-product controller around one fixed8 MAC cell. A job is
// configured on the cfg channel (length + operand signedness), consumes
// cfg_len operand pairs on the op channel, then presents the accumulated
// sum on the res channel until it is accepted or the job is aborted.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        job request handshake
//   cfg_len [LEN_W-1:0]        number of operand pairs in the job
//   cfg_s_in, cfg_s_weight     activation / weight signedness
//   abort                      synchronous cancel (RUN or DONE only)
//   op_valid/op_ready          operand pair handshake
//   op_in, op_weight [7:0]     activation and weight bytes
//   res_valid/res_ready        result handshake
//   res_data [ACC_W-1:0]       accumulated dot product
//   busy                       high in any state other than IDLE
// -----------------------------------------------------------------------------
module fixed8_mac_seq
  import fixed8_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_s_in,
  input  logic                   cfg_s_weight,
  input  logic                   abort,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [7:0]             op_in,
  input  logic [7:0]             op_weight,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*COL_WIDTH-1:0] res_data,
  output logic                   busy
);

  localparam int ACC_W = 4 * COL_WIDTH;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] psum_fwd_s;
  logic [LEN_W-1:0] cnt_r;
  logic             s_in_r;
  logic             s_weight_r;
  logic             cfg_ready_r;
  logic             op_ready_r;
  logic             res_valid_r;
  logic             busy_r;

  logic             cfg_xfer_s;
  logic             op_xfer_s;
  logic             res_xfer_s;
  logic             len_zero_s;
  logic             cnt_last_s;

  // Handshake qualifiers. The ready terms come from registered state flags,
  // so a transfer is exactly "valid and ready at the rising edge".
  assign cfg_xfer_s = cfg_valid & cfg_ready_r;
  assign op_xfer_s  = op_valid & op_ready_r & ~abort;
  assign res_xfer_s = res_ready & res_valid_r;
  assign len_zero_s = (cfg_len == {LEN_W{1'b0}});
  assign cnt_last_s = (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1});

  // Single MAC cell; its forward sum is the accumulator's next value.
  fixed8 #(
    .ACC_W (ACC_W)
  ) u_fixed8 (
    .in       (op_in),
    .weight   (op_weight),
    .s_in     (s_in_r),
    .s_weight (s_weight_r),
    .psum_in  (acc_r),
    .psum_fwd (psum_fwd_s)
  );

  // Next-state logic; abort outranks both op and res transfers.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_xfer_s) begin
          if (len_zero_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (op_xfer_s && cnt_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort || res_xfer_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered per-state output flags, all decoded from
  // the next state so they line up with state_r on every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_ready_r <= 1'b1;
      op_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cfg_ready_r <= (state_nxt_s == ST_IDLE);
      op_ready_r  <= (state_nxt_s == ST_RUN);
      res_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Job datapath: configuration latch, accumulator and remaining count.
  // Nothing here moves in DONE, which keeps res_data stable while offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= {ACC_W{1'b0}};
      cnt_r      <= {LEN_W{1'b0}};
      s_in_r     <= 1'b0;
      s_weight_r <= 1'b0;
    end else if (cfg_xfer_s) begin
      acc_r      <= {ACC_W{1'b0}};
      cnt_r      <= cfg_len;
      s_in_r     <= cfg_s_in;
      s_weight_r <= cfg_s_weight;
    end else if (op_xfer_s) begin
      acc_r      <= psum_fwd_s;
      cnt_r      <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      acc_r      <= acc_r;
      cnt_r      <= cnt_r;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign op_ready  = op_ready_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;
  assign res_data  = acc_r;

endmodule : fixed8_mac_seq

// File: tb/tb_fixed8_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_fixed8_mac_seq
// Self-checking bench for fixed8_mac_seq: a table of directed jobs, a set of
// hand-written abort/reset/handshake sequences, and random jobs checked
// against a plain-arithmetic dot-product model.
// -----------------------------------------------------------------------------
module tb_fixed8_mac_seq;

  localparam int ACC_W = 44;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_s_in;
  logic             cfg_s_weight;
  logic             abort;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_in;
  logic [7:0]       op_weight;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  int errs;
  int checks;

  logic [7:0] ins [256];
  logic [7:0] ws  [256];

  typedef struct {
    int          len;
    bit          si;
    bit          sw;
    logic [31:0] vin;
    logic [31:0] vw;
    logic [43:0] exp;
    int          mode;
    int          hold;
  } vec_t;

  vec_t tbl [6];

  fixed8_mac_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_len      (cfg_len),
    .cfg_s_in     (cfg_s_in),
    .cfg_s_weight (cfg_s_weight),
    .abort        (abort),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_in        (op_in),
    .op_weight    (op_weight),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Reference: sum of products of operands interpreted per the flags, mod 2^ACC_W.
  function automatic logic [ACC_W-1:0] ref_dot(input int len, input bit si, input bit sw);
    longint sum;
    longint a;
    longint b;
    sum = 0;
    for (int k = 0; k < len; k++) begin
      a = si ? longint'($signed(ins[k])) : longint'({56'd0, ins[k]});
      b = sw ? longint'($signed(ws[k]))  : longint'({56'd0, ws[k]});
      sum = sum + a * b;
    end
    return sum[ACC_W-1:0];
  endfunction

  // mode 0: op_valid always high; 1: stall on even cycles; 2: random stalls.
  task automatic run_job(input int len, input bit si, input bit sw, input int mode,
                         input int hold, input logic [ACC_W-1:0] exp, input string tag);
    int i;
    int cyc;
    @(negedge clk);
    check({tag, " cfg_ready"}, {63'd0, cfg_ready}, 64'd1);
    cfg_valid    = 1'b1;
    cfg_len      = len[LEN_W-1:0];
    cfg_s_in     = si;
    cfg_s_weight = sw;
    @(negedge clk);
    cfg_valid    = 1'b0;
    cfg_len      = LEN_W'($urandom);
    cfg_s_in     = 1'($urandom);
    cfg_s_weight = 1'($urandom);
    i   = 0;
    cyc = 0;
    while (i < len && cyc < 4 * len + 20) begin
      check({tag, " op_ready"}, {62'd0, op_ready, busy}, 64'd3);
      case (mode)
        0:       op_valid = 1'b1;
        1:       op_valid = cyc[0];
        default: op_valid = ($urandom_range(0, 3) != 0);
      endcase
      op_in     = ins[i];
      op_weight = ws[i];
      cfg_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (op_valid) i++;
      cyc++;
    end
    op_valid  = 1'b0;
    cfg_valid = 1'b0;
    op_in     = 8'($urandom);
    op_weight = 8'($urandom);
    if (mode == 1) check({tag, " run_cycles"}, 64'(cyc), 64'(2 * len));
    check({tag, " res_valid"}, {62'd0, res_valid, busy}, 64'd3);
    check({tag, " res_data"}, {20'd0, res_data}, {20'd0, exp});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold"}, {19'd0, res_valid, res_data}, {19'd0, 1'b1, exp});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " idle"}, {61'd0, cfg_ready, res_valid, busy}, 64'd4);
  endtask

  task automatic load_vec(input int v);
    for (int k = 0; k < 4; k++) begin
      ins[k] = tbl[v].vin[8*k +: 8];
      ws[k]  = tbl[v].vw[8*k +: 8];
    end
  endtask

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_len = '0; cfg_s_in = 1'b0;
    cfg_s_weight = 1'b0; abort = 1'b0; op_valid = 1'b0; op_in = 8'd0;
    op_weight = 8'd0; res_ready = 1'b0;

    // len, si, sw, ins (byte0 = first pair), weights, expected, mode, hold
    tbl[0] = '{3, 1'b0, 1'b0, 32'h00FF0402, 32'h00FF0503, 44'd65051, 0, 0};
    tbl[1] = '{2, 1'b1, 1'b1, 32'h0000FF80, 32'h00000180, 44'd16383, 0, 1};
    tbl[2] = '{1, 1'b1, 1'b0, 32'h000000FF, 32'h000000FF, 44'hFFF_FFFF_FF01, 0, 0};
    tbl[3] = '{0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 44'd0, 0, 5};
    tbl[4] = '{4, 1'b0, 1'b0, 32'h281E140A, 32'h04030201, 44'd300, 1, 0};
    tbl[5] = '{2, 1'b0, 1'b1, 32'h000001C8, 32'h00007FFE, 44'hFFF_FFFF_FEEF, 0, 2};

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    check("reset outputs", {60'd0, cfg_ready, op_ready, res_valid, busy}, 64'h8);
    check("reset res_data", {20'd0, res_data}, 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_job(tbl[v].len, tbl[v].si, tbl[v].sw, tbl[v].mode, tbl[v].hold,
              tbl[v].exp, $sformatf("vec%0d", v));
    end

    // Stalled length-4 job must match the same job without stalls.
    load_vec(4);
    run_job(4, 1'b0, 1'b0, 0, 0, 44'd300, "nostall");

    // Abort after the 2nd of 5 transfers, with a same-cycle op offered.
    for (int k = 0; k < 5; k++) begin ins[k] = 8'(k + 7); ws[k] = 8'(k + 3); end
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 8'd5; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1; op_in = ins[k]; op_weight = ws[k];
      @(negedge clk);
    end
    abort = 1'b1; op_in = ins[2]; op_weight = ws[2];
    @(negedge clk);
    abort = 1'b0; op_valid = 1'b0;
    check("abort run", {60'd0, cfg_ready, op_ready, res_valid, busy}, 64'h8);
    @(negedge clk);
    check("abort no res", {63'd0, res_valid}, 64'd0);
    load_vec(0);
    run_job(3, 1'b0, 1'b0, 0, 0, 44'd65051, "after_abort");

    // Abort while DONE drops the result; abort in IDLE does not block cfg.
    @(negedge clk);
    abort = 1'b1; cfg_valid = 1'b1; cfg_len = 8'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("abort idle ignored", {62'd0, res_valid, busy}, 64'd3);
    @(negedge clk);
    abort = 1'b0;
    check("abort done", {61'd0, cfg_ready, res_valid, busy}, 64'd4);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 8'd5; cfg_s_in = 1'b1; cfg_s_weight = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; op_valid = 1'b1; op_in = 8'd9; op_weight = 8'd9;
    @(negedge clk);
    check("pre-reset run", {63'd0, op_ready}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {60'd0, cfg_ready, op_ready, res_valid, busy}, 64'h8);
    check("async reset res_data", {20'd0, res_data}, 64'd0);
    op_valid = 1'b0;
    #5 rst_n = 1'b1;
    load_vec(1);
    run_job(2, 1'b1, 1'b1, 0, 0, 44'd16383, "after_reset");

    // Random jobs against the reference model.
    for (int r = 0; r < 25; r++) begin
      int len;
      bit si;
      bit sw;
      len = $urandom_range(0, 12);
      si  = 1'($urandom);
      sw  = 1'($urandom);
      for (int k = 0; k < len; k++) begin ins[k] = 8'($urandom); ws[k] = 8'($urandom); end
      run_job(len, si, sw, 2, $urandom_range(0, 3), ref_dot(len, si, sw),
              $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_fixed8_mac_seq
